// File: rtl/data_interlayer_if.sv
// Data-bus bundle between the interlayer (master) and the SRAM-like
// data-bus bridge (slave).
interface data_interlayer_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_interlayer.sv
// data_interlayer: queues MA data-memory requests in a 2-entry FIFO and
// replays them one at a time on the SRAM-like data bus; load data returns
// as a registered one-cycle pulse.
// Optional macro DATA_INTERLAYER_POSTED_WR_EN: when defined, MA is stalled
// only when the FIFO is full (posted mode); otherwise every request blocks
// further acceptance until the bus transaction has fully completed.
//
// state  | meaning
// IDLE   | no bus request; waiting for a queued request
// REQ    | data_req high, FIFO head presented until data_addr_ok
// WAIT   | one transaction outstanding; waiting for data_data_ok
module data_interlayer (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_size,
  input  logic [31:0] mem_wdata,
  output logic        interlayer_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        ovf,
  data_interlayer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // Entries hold the already bus-mapped fields so the head can drive the
  // bus directly and stays stable under backpressure.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      fifo_q [2];
  entry_t      new_entry;
  entry_t      head;
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        wr_q;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic        ovf_q;
  logic        req_any;
  logic        push;
  logic        pop;

  function automatic logic [1:0] low_lane(input logic [3:0] strb);
    if (strb[0])      return 2'd0;
    else if (strb[1]) return 2'd1;
    else if (strb[2]) return 2'd2;
    else if (strb[3]) return 2'd3;
    else              return 2'd0;
  endfunction

`ifdef DATA_INTERLAYER_POSTED_WR_EN
  assign interlayer_ready = (count_q < 2'd2);
`else
  assign interlayer_ready = (count_q == 2'd0) && (state_q == S_IDLE);
`endif

  assign req_any = mem_read | mem_write;
  assign push    = req_any && interlayer_ready;
  assign pop     = (state_q == S_REQ) && bus.data_addr_ok;
  assign head    = fifo_q[rd_ptr_q];

  // Map an incoming MA request onto bus fields; stores win over loads.
  always_comb begin
    new_entry       = '0;
    new_entry.wr    = mem_write;
    new_entry.wdata = mem_wdata;
    if (mem_write) begin
      new_entry.wstrb = mem_wstrb;
      new_entry.addr  = {mem_addr[31:2], low_lane(mem_wstrb)};
      case (mem_size)
        3'd1:    new_entry.size = 2'd0;
        3'd2:    new_entry.size = 2'd1;
        default: new_entry.size = 2'd2;
      endcase
    end else begin
      new_entry.size = 2'd2;
      new_entry.addr = mem_addr;
    end
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_p) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a push this cycle counts as non-empty next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (count_q != 2'd0 || push) state_d = S_REQ;
      S_REQ:  if (bus.data_addr_ok)        state_d = S_WAIT;
      S_WAIT: if (bus.data_data_ok)
                state_d = (count_q != 2'd0 || push) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the bus is driven from the FIFO head only in REQ.
  always_comb begin
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'd0;
    bus.data_addr  = 32'd0;
    bus.data_wstrb = 4'd0;
    bus.data_wdata = 32'd0;
    if (state_q == S_REQ) begin
      bus.data_req   = 1'b1;
      bus.data_wr    = head.wr;
      bus.data_size  = head.size;
      bus.data_addr  = head.addr;
      bus.data_wstrb = head.wstrb;
      bus.data_wdata = head.wdata;
    end
  end

  // Completion tracking, load-data return and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      wr_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      if (pop) wr_q <= head.wr;
      rd_valid_q <= 1'b0;
      if (state_q == S_WAIT && bus.data_data_ok && !wr_q) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.data_rdata;
      end
      if (req_any && !interlayer_ready) ovf_q <= 1'b1;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/data_interlayer.md
# data_interlayer

Memory-side responder for the MA stage's data-memory requests. It accepts read and write requests (word-aligned address, byte size, write strobes, write data), queues them, and replays them one at a time on the SRAM-like data bus. It returns load data to WB as a registered one-cycle pulse. It sits between MA and the data-bus bridge and drives `interlayer_ready` back to MA.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_p  in  1  synchronous, active-high reset
- mem_read  in  1  MA load request, valid for one cycle
- mem_write  in  1  MA store request, valid for one cycle
- mem_wstrb  in  4  byte strobes for stores
- mem_addr  in  32  request address; low 2 bits are always 0
- mem_size  in  3  access size in bytes (1, 2, 4)
- mem_wdata  in  32  store data, already lane-aligned
- interlayer_ready  out  1  a request can be accepted this cycle
- rd_valid  out  1  one-cycle pulse: rd_data holds load data
- rd_data  out  32  load data, full word
- ovf  out  1  sticky: a request was presented while not ready and was dropped
- data_req  out  1  bus request
- data_wr  out  1  bus request is a write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wstrb  out  4  bus byte strobes
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  bus accepted the request this cycle
- data_data_ok  in  1  bus completed the outstanding request this cycle
- data_rdata  in  32  bus read data, valid with data_data_ok

## Operation
**Request queue**
- 2-entry FIFO. Each entry holds {wr, size, addr, wstrb, wdata}.
- Push when `(mem_read|mem_write) && interlayer_ready`. `mem_write` wins if both are high.
- If a request arrives while `interlayer_ready` is 0, it is dropped and `ovf` is set. `ovf` stays set until reset.

**FSM states**
- IDLE: `data_req` = 0. Go to REQ when the FIFO is non-empty.
- REQ: `data_req` = 1, driven from the FIFO head. On `data_addr_ok`, pop the head, latch its `wr` flag, and go to WAIT.
- WAIT: `data_req` = 0. On `data_data_ok`:
  - If the latched flag is read, register `rd_data <= data_rdata` and pulse `rd_valid` on the next cycle.
  - Then go to REQ if the FIFO is non-empty, otherwise to IDLE.
  - Write completions produce no output.
- `data_data_ok` is ignored in IDLE and REQ. `data_addr_ok` is ignored outside REQ.

**Bus field mapping**
- Reads are always full-word reads: `data_size` = 2, `data_addr` = `mem_addr`, `data_wstrb` = 0. WB extracts the needed bytes.
- Writes: `data_addr[31:2]` = `mem_addr[31:2]`. `data_addr[1:0]` = index of the lowest set bit of `wstrb` (0 if `wstrb` = 0).
- Write `data_size`: `mem_size` 1→0, 2→1, 4→2. Any other value→2.
- `data_wstrb` and `data_wdata` are passed through unchanged.
- All bus outputs are stable while `data_req` = 1 and `data_addr_ok` = 0.

**Boundary conditions**
- Push and pop in the same cycle leave the count unchanged.
- `interlayer_ready` is computed from registered state only, with no combinational path from `mem_*` or bus inputs. A push attempted on a full FIFO in the same cycle as a pop is therefore still dropped.
- Reset mid-transaction: FIFO is cleared, FSM goes to IDLE, and any bus response still in flight is ignored.

## Timing
**Reset values**
- `interlayer_ready` = 1.
- `rd_valid`, `ovf`, `data_req`, `data_wr` = 0.
- `rd_data` = 0, `data_addr` = 0, `data_wstrb` = 0, `data_wdata` = 0, `data_size` = 0.

**Latency**
- Request accepted at cycle T → `data_req` = 1 at T+1.
- `data_addr_ok` at A → WAIT from A+1.
- `data_data_ok` at D → `rd_valid` at D+1. The next queued request raises `data_req` at D+1.
- Minimum load latency with zero-wait bus: accept T, `rd_valid` T+3.
- At most one bus transaction is outstanding.

## Configuration
`DATA_INTERLAYER_POSTED_WR_EN` selects how `interlayer_ready` is computed.

- Defined: posted mode.
  - `interlayer_ready` = FIFO count < 2.
  - A store occupies MA for only its accept cycle; up to 2 requests may be queued behind the outstanding one.
- Undefined: serialized mode.
  - `interlayer_ready` = FIFO empty && FSM in IDLE.
  - Every request, store or load, blocks further acceptance until its `data_data_ok` has been received and the FSM has returned to IDLE.

## Test plan
- Load, zero-wait bus: `mem_read`, addr 0x1000, size 1 at T; `addr_ok` at T+1; `data_ok` with `rdata` 0xDEADBEEF at T+2 → `data_size` = 2, `data_addr` = 0x1000; `rd_valid` = 1 with `rd_data` = 0xDEADBEEF at T+3 only.
- Store byte: addr 0x2000, `wstrb` 0100, `wdata` 0x00AB0000, size 1 → `data_wr` = 1, `data_addr` = 0x2002, `data_size` = 0, `data_wstrb` = 0100; `rd_valid` never asserted.
- Bus backpressure: `addr_ok` held low for 5 cycles → `data_req` and all bus fields stay constant for 5 cycles; pop happens on the `addr_ok` cycle.
- Posted mode: two stores on consecutive cycles while the bus stalls → `interlayer_ready` goes 0 after the second push; a third request while not ready sets `ovf` = 1; both stores then issue in order.
- Serialized mode: store then load → `interlayer_ready` = 0 from accept until the cycle after the store's `data_ok`; the load's `data_req` follows.
- Reset during WAIT: assert `rst_p`, then deliver `data_ok` → no `rd_valid`, `interlayer_ready` = 1, FIFO empty.
